// File: rtl/sig_dump_reader.sv
// Signature dump reader: on a halt rising edge, walks [sig_start, sig_end) over an
// AXI4-Lite read master and streams the 32-bit words out in ascending address order.
//
// state | meaning
// IDLE  | waiting for the first halt rising edge after reset
// ADDR  | AR channel valid, holding the 64-bit aligned address until arready
// RESP  | rready high, waiting for the single outstanding R beat
// EMIT  | sig_valid high with the selected word until sig_ready
// FIN   | dump over, done (and maybe error) held until the next halt edge
module sig_dump_reader #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              halt,
    input  logic [ADDR_W-1:0] sig_start,
    input  logic [ADDR_W-1:0] sig_end,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic [31:0]       sig_word,
    output logic              sig_valid,
    input  logic              sig_ready,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {IDLE, ADDR, RESP, EMIT, FIN} state_t;

    state_t            state;
    logic              halt_d;
    logic              halt_rise;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] end_addr;
    logic [ADDR_W:0]   addr_nxt_wide;
    logic [ADDR_W-1:0] addr_nxt;
    logic              addr_more;

    assign halt_rise     = halt & ~halt_d;
    // One extra bit so an increment that wraps the address space never looks below end_addr.
    assign addr_nxt_wide = {1'b0, addr} + (ADDR_W+1)'(4);
    assign addr_nxt      = addr_nxt_wide[ADDR_W-1:0];
    assign addr_more     = addr_nxt_wide < {1'b0, end_addr};

    function automatic logic [ADDR_W-1:0] align8(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:3], 3'b000};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            halt_d    <= 1'b0;
            addr      <= '0;
            end_addr  <= '0;
            m_araddr  <= '0;
            m_arvalid <= 1'b0;
            m_rready  <= 1'b0;
            sig_word  <= '0;
            sig_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            halt_d <= halt;
            case (state)
                IDLE, FIN: begin
                    if (halt_rise) begin
                        addr     <= sig_start;
                        end_addr <= sig_end;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        if (sig_start[1:0] != 2'b00 || sig_end[1:0] != 2'b00) begin
                            done  <= 1'b1;
                            error <= 1'b1;
                            state <= FIN;
                        end else if (sig_end <= sig_start) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            m_araddr  <= align8(sig_start);
                            m_arvalid <= 1'b1;
                            busy      <= 1'b1;
                            state     <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (m_rvalid) begin
                        m_rready <= 1'b0;
                        if (m_rresp == 2'b00) begin
                            // Lower-addressed word lives in the upper half of the beat.
                            sig_word  <= addr[2] ? m_rdata[31:0] : m_rdata[63:32];
                            sig_valid <= 1'b1;
                            state     <= EMIT;
                        end else begin
                            error <= 1'b1;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= FIN;
                        end
                    end
                end
                EMIT: begin
                    if (sig_ready) begin
                        sig_valid <= 1'b0;
                        addr      <= addr_nxt;
                        if (addr_more) begin
                            m_araddr  <= align8(addr_nxt);
                            m_arvalid <= 1'b1;
                            state     <= ADDR;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sig_dump_reader.sv
// Directed bench for sig_dump_reader: simple AXI4-Lite slave model whose beat at aligned
// address A holds {A+0x1000_0000, A+0x1000_0004} (low 32 bits), plus stream/AR monitors.
module tb_sig_dump_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halt;
    logic [63:0] sig_start, sig_end;
    logic [63:0] m_araddr;
    logic        m_arvalid, m_arready;
    logic [63:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid, m_rready;
    logic [31:0] sig_word;
    logic        sig_valid, sig_ready;
    logic        busy, done, error;

    int n_chk = 0, n_pass = 0;
    logic [31:0] words[$];
    logic [63:0] ars[$];
    int  beat_idx = 0;
    int  err_beat = -1;
    bit  r_hold = 1'b0;
    int  s_st = 0;
    logic [63:0] s_addr;

    sig_dump_reader #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .halt(halt),
        .sig_start(sig_start), .sig_end(sig_end),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .sig_word(sig_word), .sig_valid(sig_valid), .sig_ready(sig_ready),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem(input logic [63:0] a);
        logic [31:0] lo;
        lo = a[31:0];
        return {lo + 32'h1000_0000, lo + 32'h1000_0004};
    endfunction

    // AXI slave: arready one cycle after arvalid, R beat two cycles after that
    initial begin
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                s_st = 0; m_arready = 1'b0; m_rvalid = 1'b0;
            end else begin
                case (s_st)
                    0: if (m_arvalid) begin m_arready = 1'b1; s_addr = m_araddr; s_st = 1; end
                    1: begin m_arready = 1'b0; s_st = 2; end
                    2: if (!r_hold) begin
                           m_rvalid = 1'b1;
                           m_rdata  = mem(s_addr);
                           m_rresp  = (beat_idx == err_beat) ? 2'b10 : 2'b00;
                           s_st = 3;
                       end
                    default: begin m_rvalid = 1'b0; beat_idx++; s_st = 0; end
                endcase
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && sig_valid && sig_ready) words.push_back(sig_word);
        if (rst_n && m_arvalid && m_arready) ars.push_back(m_araddr);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin ok = 1'b1; return; end
        end
    endtask

    task automatic start_dump(input logic [63:0] s, input logic [63:0] e);
        halt = 1'b0;
        cyc(1);
        sig_start = s; sig_end = e;
        words.delete(); ars.delete();
        beat_idx = 0;
        halt = 1'b1;
    endtask

    initial begin
        bit ok;
        logic [31:0] w0;
        int n_ar;
        rst_n = 1'b0; halt = 1'b0; sig_ready = 1'b1;
        sig_start = '0; sig_end = '0;
        cyc(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_arvalid", m_arvalid, 0);
        chk("rst_sig_valid", sig_valid, 0);
        chk("rst_araddr", m_araddr, 0);
        rst_n = 1'b1;
        cyc(2);

        // basic 4-word dump
        start_dump(64'h80_0000_0100, 64'h80_0000_0110);
        wait_done(ok);
        chk("basic_done_to", ok, 1);
        chk("basic_nwords", words.size(), 4);
        chk("basic_w0", words[0], 32'h1000_0100);
        chk("basic_w1", words[1], 32'h1000_0104);
        chk("basic_w2", words[2], 32'h1000_0108);
        chk("basic_w3", words[3], 32'h1000_010C);
        chk("basic_nar", ars.size(), 4);
        chk("basic_ar0", ars[0], 64'h80_0000_0100);
        chk("basic_ar1", ars[1], 64'h80_0000_0100);
        chk("basic_ar2", ars[2], 64'h80_0000_0108);
        chk("basic_ar3", ars[3], 64'h80_0000_0108);
        chk("basic_error", error, 0);
        chk("basic_busy", busy, 0);

        // sink back-pressure, restart from FIN clears done
        sig_ready = 1'b0;
        start_dump(64'h80_0000_0100, 64'h80_0000_0110);
        cyc(1);
        chk("bp_done_cleared", done, 0);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (sig_valid === 1'b1) ok = 1'b1;
        end
        chk("bp_valid_to", ok, 1);
        w0 = sig_word;
        n_ar = ars.size();
        chk("bp_w0", w0, 32'h1000_0100);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid_held", sig_valid, 1);
            chk("bp_word_stable", sig_word, w0);
            chk("bp_no_new_ar", m_arvalid, 0);
        end
        chk("bp_ar_count", ars.size(), n_ar);
        sig_ready = 1'b1;
        wait_done(ok);
        chk("bp_done_to", ok, 1);
        chk("bp_nwords", words.size(), 4);
        chk("bp_w3", words[3], 32'h1000_010C);

        // error response on second beat
        err_beat = 1;
        start_dump(64'h80_0000_0100, 64'h80_0000_0110);
        wait_done(ok);
        err_beat = -1;
        chk("rresp_done_to", ok, 1);
        chk("rresp_nwords", words.size(), 1);
        chk("rresp_w0", words[0], 32'h1000_0100);
        chk("rresp_error", error, 1);
        chk("rresp_busy", busy, 0);
        chk("rresp_nar", ars.size(), 2);

        // misaligned start
        start_dump(64'h80_0000_0102, 64'h80_0000_0110);
        cyc(2);
        chk("misal_done", done, 1);
        chk("misal_error", error, 1);
        chk("misal_busy", busy, 0);
        chk("misal_nar", ars.size(), 0);
        chk("misal_nwords", words.size(), 0);

        // empty range
        start_dump(64'h80_0000_0100, 64'h80_0000_0100);
        cyc(2);
        chk("empty_done", done, 1);
        chk("empty_error", error, 0);
        chk("empty_nar", ars.size(), 0);

        // top of address space
        start_dump(64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFFC);
        wait_done(ok);
        chk("top_done_to", ok, 1);
        chk("top_nwords", words.size(), 3);
        chk("top_w2", words[2], 32'h0FFF_FFF8);
        chk("top_ar2", ars[2], 64'hFFFF_FFFF_FFFF_FFF8);
        chk("top_error", error, 0);

        // halt toggling while busy is ignored
        start_dump(64'h80_0000_0100, 64'h80_0000_0110);
        cyc(3);
        chk("tog_busy", busy, 1);
        halt = 1'b0; cyc(1); halt = 1'b1; cyc(2);
        halt = 1'b0; cyc(1); halt = 1'b1;
        wait_done(ok);
        chk("tog_done_to", ok, 1);
        chk("tog_nwords", words.size(), 4);
        chk("tog_nar", ars.size(), 4);
        chk("tog_w0", words[0], 32'h1000_0100);

        // async reset while waiting in RESP, halt left high across release
        r_hold = 1'b1;
        start_dump(64'h80_0000_0100, 64'h80_0000_0110);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (m_rready === 1'b1) ok = 1'b1;
        end
        chk("rst_mid_resp_to", ok, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_rready", m_rready, 0);
        chk("arst_arvalid", m_arvalid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_araddr", m_araddr, 0);
        chk("arst_sig_word", sig_word, 0);
        @(negedge clk);
        r_hold = 1'b0;
        words.delete(); ars.delete(); beat_idx = 0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_busy", busy, 1);
        wait_done(ok);
        chk("rel_done_to", ok, 1);
        chk("rel_nwords", words.size(), 4);
        chk("rel_w1", words[1], 32'h1000_0104);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
